// File: rtl/drive_pwm_ctrl.sv
// drive_pwm_ctrl
//   Turns drive commands from the serial receiver into soft-ramped PWM and
//   direction signals for the left and right H-bridges. Both motors share
//   one duty value; only the direction bits differ. A link-loss watchdog
//   forces a ramped stop when commands stop arriving.
//
// Ports
//   i_Clock      system clock
//   i_Reset_n    asynchronous active-low reset
//   i_Cmd_Valid  one-cycle command strobe from the receiver
//   i_DriveCMD   command level: 0 STOP, 1 FORWARD, 2 SPIN, 3 reserved (STOP)
//   o_PWM_L/R    motor PWM, identical every cycle
//   o_Dir_L/R    direction, 1 = forward
//   o_Mode       mode applied to the outputs: 0 stop, 1 forward, 2 spin
//   o_Wdog_Trip  high while a watchdog stop is in force
module drive_pwm_ctrl #(
  parameter int PWM_BITS    = 8,
  parameter int DUTY_MAX    = 200,
  parameter int DUTY_STEP   = 10,
  parameter int RAMP_TICKS  = 50000,
  parameter int WDOG_CYCLES = 50000000
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Cmd_Valid,
  input  logic [1:0] i_DriveCMD,
  output logic       o_PWM_L,
  output logic       o_PWM_R,
  output logic       o_Dir_L,
  output logic       o_Dir_R,
  output logic [1:0] o_Mode,
  output logic       o_Wdog_Trip
);

  localparam int PRESC_W = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
  localparam int DUTY_W  = PWM_BITS + 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(RAMP_TICKS - 1);
  localparam logic [25:0]        WDOG_LAST  = 26'(WDOG_CYCLES - 1);
  localparam logic [DUTY_W-1:0]  STEP_X     = DUTY_W'(DUTY_STEP);
  localparam logic [DUTY_W-1:0]  MAX_X      = DUTY_W'(DUTY_MAX);

  localparam logic [1:0] MODE_STOP = 2'd0;
  localparam logic [1:0] MODE_FWD  = 2'd1;
  localparam logic [1:0] MODE_SPIN = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RUN       = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                cmd_pend_q;
  logic [1:0]          target_q, target_d;
  logic [25:0]         wdog_q, wdog_d;
  logic                trip_q, trip_d;
  logic                wdog_sat;
  logic [PRESC_W-1:0]  presc_q;
  logic                tick;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [1:0]          mode_q, mode_d;
  logic                dir_l_q, dir_l_d;
  logic                dir_r_q, dir_r_d;
  logic                pwm_q;
  logic [DUTY_W-1:0]   duty_x, duty_sum, duty_up, duty_dn;

  assign tick = (presc_q == PRESC_LAST);

  // Command capture and watchdog. The receiver presents the new level one
  // clock after its strobe, so the level is sampled while cmd_pend_q is high.
  // A strobe in the saturation cycle clears the counter and suppresses the trip.
  always_comb begin
    wdog_sat = (wdog_q == WDOG_LAST);
    wdog_d   = wdog_q;
    trip_d   = trip_q;
    target_d = target_q;
    if (i_Cmd_Valid) begin
      wdog_d = '0;
      trip_d = 1'b0;
    end else if (!wdog_sat) begin
      wdog_d = wdog_q + 1'b1;
    end else begin
      trip_d = 1'b1;
    end
    if (cmd_pend_q) begin
      target_d = (i_DriveCMD == 2'd3) ? MODE_STOP : i_DriveCMD;
    end else if (wdog_sat && !i_Cmd_Valid) begin
      target_d = MODE_STOP;
    end
  end

  // Saturating ramp arithmetic, one bit wider so the sum cannot wrap.
  always_comb begin
    duty_x   = {1'b0, duty_q};
    duty_sum = duty_x + STEP_X;
    duty_up  = (duty_sum >= MAX_X) ? MAX_X : duty_sum;
    duty_dn  = (duty_x > STEP_X) ? (duty_x - STEP_X) : '0;
  end

  // Next-state logic. A target/mode mismatch outranks a ramp tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (target_q != MODE_STOP) state_d = ST_RAMP_UP;
      ST_RAMP_UP: begin
        if (target_q != mode_q)            state_d = ST_RAMP_DOWN;
        else if (tick && (duty_up == MAX_X)) state_d = ST_RUN;
      end
      ST_RUN:       if (target_q != mode_q)   state_d = ST_RAMP_DOWN;
      ST_RAMP_DOWN: if (duty_q == '0)         state_d = ST_IDLE;
      default:                                state_d = ST_IDLE;
    endcase
  end

  // Duty, mode and direction. Directions are only ever latched in IDLE, where
  // duty is already zero, so the bridge never sees a live pulse across a flip.
  always_comb begin
    duty_d  = duty_q;
    mode_d  = mode_q;
    dir_l_d = dir_l_q;
    dir_r_d = dir_r_q;
    case (state_q)
      ST_IDLE: begin
        duty_d = '0;
        if (target_q != MODE_STOP) begin
          mode_d  = target_q;
          dir_l_d = (target_q == MODE_FWD);
          dir_r_d = 1'b1;
        end
      end
      ST_RAMP_UP: begin
        if ((target_q == mode_q) && tick) duty_d = duty_up[PWM_BITS-1:0];
      end
      ST_RAMP_DOWN: begin
        if (duty_q == '0)  mode_d = MODE_STOP;
        else if (tick)     duty_d = duty_dn[PWM_BITS-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q    <= ST_IDLE;
      cmd_pend_q <= 1'b0;
      target_q   <= MODE_STOP;
      wdog_q     <= '0;
      trip_q     <= 1'b0;
      presc_q    <= '0;
      pwm_cnt_q  <= '0;
      duty_q     <= '0;
      mode_q     <= MODE_STOP;
      dir_l_q    <= 1'b1;
      dir_r_q    <= 1'b1;
      pwm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_pend_q <= i_Cmd_Valid;
      target_q   <= target_d;
      wdog_q     <= wdog_d;
      trip_q     <= trip_d;
      presc_q    <= tick ? '0 : presc_q + 1'b1;
      pwm_cnt_q  <= pwm_cnt_q + 1'b1;
      duty_q     <= duty_d;
      mode_q     <= mode_d;
      dir_l_q    <= dir_l_d;
      dir_r_q    <= dir_r_d;
      pwm_q      <= (pwm_cnt_q < duty_q);
    end
  end

  assign o_PWM_L     = pwm_q;
  assign o_PWM_R     = pwm_q;
  assign o_Dir_L     = dir_l_q;
  assign o_Dir_R     = dir_r_q;
  assign o_Mode      = mode_q;
  assign o_Wdog_Trip = trip_q;

  // MODE_SPIN is documented here for readers; the datapath derives SPIN
  // directions from "not forward".
  logic unused_spin;
  assign unused_spin = ^MODE_SPIN;

endmodule

// File: tb/tb_drive_pwm_ctrl.sv
module tb_drive_pwm_ctrl;
  localparam int PWM_BITS    = 8;
  localparam int DUTY_MAX    = 200;
  localparam int DUTY_STEP   = 50;
  localparam int RAMP_TICKS  = 4;
  localparam int WDOG_CYCLES = 1000;
  localparam int PERIOD      = 1 << PWM_BITS;

  localparam int P_IDLE = 0, P_UP = 1, P_RUN = 2, P_DOWN = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       valid = 1'b0;
  logic [1:0] cmd = 2'd0;
  logic       pwm_l, pwm_r, dir_l, dir_r, trip;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;

  drive_pwm_ctrl #(
    .PWM_BITS(PWM_BITS), .DUTY_MAX(DUTY_MAX), .DUTY_STEP(DUTY_STEP),
    .RAMP_TICKS(RAMP_TICKS), .WDOG_CYCLES(WDOG_CYCLES)
  ) dut (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Cmd_Valid(valid), .i_DriveCMD(cmd),
    .o_PWM_L(pwm_l), .o_PWM_R(pwm_r), .o_Dir_L(dir_l), .o_Dir_R(dir_r),
    .o_Mode(mode), .o_Wdog_Trip(trip)
  );

  initial forever #5 clk = ~clk;

  // Reference model: edge index since reset drives prescaler and PWM counter
  // arithmetically; the watchdog count is derived from the last strobe edge.
  int m_k, m_ls, m_target, m_phase, m_duty, m_mode;
  bit m_pend, m_trip, m_dl, m_dr, m_pwm;

  task automatic m_reset();
    m_k = 0; m_ls = -1; m_pend = 0; m_target = 0; m_trip = 0;
    m_phase = P_IDLE; m_duty = 0; m_mode = 0; m_dl = 1; m_dr = 1; m_pwm = 0;
  endtask

  task automatic m_step(input bit v, input int c);
    int wd, tgt, ph, du, md;
    bit tick, tr, dl, dr;
    wd = m_k - m_ls - 1;
    if (wd > WDOG_CYCLES - 1) wd = WDOG_CYCLES - 1;
    tick = ((m_k % RAMP_TICKS) == RAMP_TICKS - 1);
    tgt = m_target; tr = m_trip;
    if (v) tr = 0; else if (wd == WDOG_CYCLES - 1) tr = 1;
    if (m_pend) tgt = (c == 3) ? 0 : c;
    else if (!v && wd == WDOG_CYCLES - 1) tgt = 0;
    ph = m_phase; du = m_duty; md = m_mode; dl = m_dl; dr = m_dr;
    case (m_phase)
      P_IDLE: begin
        du = 0;
        if (m_target != 0) begin md = m_target; dl = (m_target == 1); dr = 1; ph = P_UP; end
      end
      P_UP: begin
        if (m_target != m_mode) ph = P_DOWN;
        else if (tick) begin
          du = (m_duty + DUTY_STEP > DUTY_MAX) ? DUTY_MAX : m_duty + DUTY_STEP;
          if (du == DUTY_MAX) ph = P_RUN;
        end
      end
      P_RUN: if (m_target != m_mode) ph = P_DOWN;
      default: begin
        if (m_duty == 0) begin ph = P_IDLE; md = 0; end
        else if (tick) du = (m_duty > DUTY_STEP) ? m_duty - DUTY_STEP : 0;
      end
    endcase
    m_pwm = ((m_k % PERIOD) < m_duty);
    m_target = tgt; m_trip = tr; m_phase = ph; m_duty = du; m_mode = md; m_dl = dl; m_dr = dr;
    m_pend = v;
    if (v) m_ls = m_k;
    m_k++;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step(valid, int'(cmd));
    end
  end

  // Cycle-by-cycle comparison away from the active edge, plus a guard that
  // the left direction never flips while a PWM pulse is present.
  logic prev_dl = 1'b1;
  initial forever begin
    logic [6:0] exp_v, act_v;
    @(negedge clk);
    exp_v = {m_pwm, m_pwm, m_dl, m_dr, 2'(m_mode), m_trip};
    act_v = {pwm_l, pwm_r, dir_l, dir_r, mode, trip};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL model_cycle k=%0d {pwmL,pwmR,dirL,dirR,mode,trip} got %b want %b", m_k, act_v, exp_v);
    end
    if (rst_n && dir_l !== prev_dl) begin
      checks++;
      if (pwm_l !== 1'b0) begin
        errors++;
        $display("FAIL dir_flip_pwm got pwm=%b want 0", pwm_l);
      end
    end
    prev_dl = dir_l;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Receiver behaviour: strobe first, new level one clock later.
  task automatic send(input logic [1:0] c);
    valid = 1'b1; step(1); valid = 1'b0; cmd = c;
  endtask

  task automatic measure(output int hi_l, output int hi_r);
    hi_l = 0; hi_r = 0;
    for (int i = 0; i < PERIOD; i++) begin
      step(1);
      if (pwm_l) hi_l++;
      if (pwm_r) hi_r++;
    end
  endtask

  typedef struct {
    bit         strobe;
    logic [1:0] cmd;
    int         wait_cyc;
    int         e_mode;
    int         e_dl;
    int         e_dr;
    int         e_trip;
    int         e_duty;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int hl, hr, cnt;
    vecs[0] = '{1'b1, 2'd1,   60, 1, 1, 1, 0, 200};  // FORWARD ramp-up
    vecs[1] = '{1'b1, 2'd2,   60, 2, 0, 1, 0, 200};  // FORWARD -> SPIN
    vecs[2] = '{1'b1, 2'd1,   60, 1, 1, 1, 0, 200};  // SPIN -> FORWARD
    vecs[3] = '{1'b1, 2'd1,   60, 1, 1, 1, 0, 200};  // repeated FORWARD
    vecs[4] = '{1'b1, 2'd3,   60, 0, 1, 1, 0,   0};  // reserved = STOP
    vecs[5] = '{1'b1, 2'd1,   60, 1, 1, 1, 0, 200};
    vecs[6] = '{1'b0, 2'd1, 1000, 0, 1, 1, 1,   0};  // link loss
    vecs[7] = '{1'b1, 2'd2,   60, 2, 0, 1, 0, 200};  // strobe clears trip
    vecs[8] = '{1'b1, 2'd0,   60, 0, 0, 1, 0,   0};  // STOP keeps dirs

    #2 rst_n = 1'b0;
    step(3);
    chk("reset_mode", int'(mode), 0);
    chk("reset_dirs", int'({dir_l, dir_r}), 3);
    chk("reset_pwm", int'({pwm_l, pwm_r}), 0);
    chk("reset_trip", int'(trip), 0);
    rst_n = 1'b1;

    // Idle with no strobes.
    cnt = 0;
    for (int i = 0; i < 900; i++) begin step(1); if (pwm_l || pwm_r) cnt++; end
    chk("idle_pwm_highs", cnt, 0);
    chk("idle_mode", int'(mode), 0);
    chk("idle_dirs", int'({dir_l, dir_r}), 3);
    chk("idle_trip", int'(trip), 0);

    // Strobe lands on the exact saturation edge: the strobe wins.
    for (int i = 0; i < 200 && m_k != WDOG_CYCLES - 1; i++) step(1);
    chk("sat_align", m_k, WDOG_CYCLES - 1);
    send(2'd0);
    step(3);
    chk("strobe_beats_sat_trip", int'(trip), 0);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].strobe) send(vecs[i].cmd);
      step(vecs[i].wait_cyc);
      chk($sformatf("vec%0d_mode", i), int'(mode), vecs[i].e_mode);
      chk($sformatf("vec%0d_dirL", i), int'(dir_l), vecs[i].e_dl);
      chk($sformatf("vec%0d_dirR", i), int'(dir_r), vecs[i].e_dr);
      chk($sformatf("vec%0d_trip", i), int'(trip), vecs[i].e_trip);
      measure(hl, hr);
      chk($sformatf("vec%0d_dutyL", i), hl, vecs[i].e_duty);
      chk($sformatf("vec%0d_dutyR", i), hr, vecs[i].e_duty);
    end

    // Repeated FORWARD strobes keep the watchdog from tripping over >1000 clocks.
    send(2'd1);
    step(60);
    for (int i = 0; i < 3; i++) begin
      step(600);
      chk("refresh_trip", int'(trip), 0);
      send(2'd1);
    end
    measure(hl, hr);
    chk("refresh_duty", hl, DUTY_MAX);
    chk("refresh_trip_end", int'(trip), 0);

    // Asynchronous reset in the middle of a ramp-up at duty 100.
    send(2'd0);
    step(60);
    chk("pre_ramp_mode", int'(mode), 0);
    for (int i = 0; i < 300 && (m_k % PERIOD) != 0; i++) step(1);
    chk("pwm_align", m_k % PERIOD, 0);
    send(2'd1);
    for (int i = 0; i < 60 && m_duty != 100; i++) step(1);
    chk("ramp_reached_100", m_duty, 100);
    step(1);
    chk("pre_reset_pwm", int'(pwm_l), 1);
    chk("pre_reset_mode", int'(mode), 1);
    rst_n = 1'b0;
    #1;
    chk("async_pwm", int'({pwm_l, pwm_r}), 0);
    chk("async_mode", int'(mode), 0);
    chk("async_dirs", int'({dir_l, dir_r}), 3);
    step(2);
    rst_n = 1'b1;
    step(300);
    chk("post_reset_mode", int'(mode), 0);
    measure(hl, hr);
    chk("post_reset_pwm", hl + hr, 0);

    // Randomized traffic, including long silences that hit the watchdog.
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 59));
      if (r == 0) send(2'($urandom_range(0, 3)));
      else if (r == 1 && $urandom_range(0, 9) == 0) step(1100);
      else step(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
